// File: rtl/inv_sub_bytes_if.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_bytes_if
//  Description : Start/Busy/Done job interface for the inverse S-box engine.
//                master : requester (drives start_i / state_in_i)
//                slave  : engine    (drives busy_o / done_o / state_out_o)
//  Signals     : start_i     1    job request, honoured only while idle
//                state_in_i  128  input state, byte i = [127-8i -: 8]
//                busy_o      1    job in progress
//                done_o      1    one-cycle completion pulse
//                state_out_o 128  substituted state, same byte order
//  Revision    : 1.0 - initial release
// ============================================================================
interface inv_sub_bytes_if;
  logic         start_i;
  logic [127:0] state_in_i;
  logic         busy_o;
  logic         done_o;
  logic [127:0] state_out_o;

  modport master (
    output start_i,
    output state_in_i,
    input  busy_o,
    input  done_o,
    input  state_out_o
  );

  modport slave (
    input  start_i,
    input  state_in_i,
    output busy_o,
    output done_o,
    output state_out_o
  );
endinterface
`default_nettype wire

// File: rtl/inv_sub_bytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_bytes_engine
//  Description : AES InvSubBytes over a 128-bit state, LANES bytes per cycle,
//                with a Start/Busy/Done handshake. The input state is latched
//                when a job is accepted, so the requester may change it freely
//                afterwards. The result is valid from the Done cycle and held
//                until the next accepted job starts overwriting it.
//  Parameters  : LANES  bytes substituted per cycle (1, 2, 4, 8 or 16)
//  Ports       : clk  clock, rising edge
//                rst  asynchronous active-high reset, aborts any job
//                bus  inv_sub_bytes_if.slave (start/state_in/busy/done/out)
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_engine #(
  parameter int LANES = 1
) (
  input  logic           clk,
  input  logic           rst,
  inv_sub_bytes_if.slave bus
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

  // FIPS-197 inverse S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] C_INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] f_inv_sbox(input logic [7:0] x);
    return C_INV_SBOX[x];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // [0:15] ordering makes element i equal to byte i of the AES state.
  logic [0:15][7:0] in_q, in_d;
  logic [0:15][7:0] out_q, out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          in_d    = bus.state_in_i;
          cnt_d   = '0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // Substitute the group of LANES bytes selected by the counter.
        for (int l = 0; l < LANES; l++) begin
          out_d[4'(32'(cnt_q) * LANES + l)] =
            f_inv_sbox(in_q[4'(32'(cnt_q) * LANES + l)]);
        end
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.state_out_o = out_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_sub_bytes_engine
//  Description : Bench for inv_sub_bytes_engine with LANES = 1, 4 and 16
//                instances sharing one stimulus stream. A job-level model
//                derives the S-box from GF(2^8) arithmetic and predicts
//                Busy/Done/State_Out every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] state_in = '0;

  logic [2:0]   busy_w;
  logic [2:0]   done_w;
  logic [127:0] out_w [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_sub_bytes_if u_if ();
    assign u_if.start_i    = start;
    assign u_if.state_in_i = state_in;
    assign busy_w[g]       = u_if.busy_o;
    assign done_w[g]       = u_if.done_o;
    assign out_w[g]        = u_if.state_out_o;
    inv_sub_bytes_engine #(.LANES((g == 0) ? 1 : (g == 1) ? 4 : 16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
  end

  // ---------------- reference tables from GF(2^8) arithmetic ----------------
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] inv_state(input logic [127:0] v);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = isb[v[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic int nof(input int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- job-level model ----------------
  // ph = 0 idle, 1..N substitution cycles, N+1 completion cycle.
  int           ph      [3] = '{0, 0, 0};
  logic [127:0] lat     [3] = '{default: '0};
  logic [127:0] exp_out [3] = '{default: '0};
  bit           out_ok  [3] = '{1, 1, 1};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        ph[d] = 0; exp_out[d] = '0; out_ok[d] = 1'b1;
      end else if (ph[d] == 0) begin
        if (start) begin
          lat[d] = state_in; ph[d] = 1; out_ok[d] = 1'b0;
        end
      end else if (ph[d] == nof(d) + 1) begin
        ph[d] = 0;
      end else begin
        ph[d] = ph[d] + 1;
        if (ph[d] == nof(d) + 1) begin
          exp_out[d] = inv_state(lat[d]); out_ok[d] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("busy[%0d]", d), 128'(busy_w[d]), 128'(ph[d] != 0));
      chk($sformatf("done[%0d]", d), 128'(done_w[d]), 128'(ph[d] == nof(d) + 1));
      if (out_ok[d]) chk($sformatf("state_out[%0d]", d), out_w[d], exp_out[d]);
    end
  end

  // ---------------- directed/random stimulus ----------------
  int first_done [3];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One job, then wait until every instance has signalled Done.
  task automatic run_job(input logic [127:0] din, input logic [127:0] want, input string nm);
    @(negedge clk);
    start = 1'b1; state_in = din;
    @(negedge clk);
    start = 1'b0; state_in = rnd128();
    for (int d = 0; d < 3; d++) first_done[d] = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        if (done_w[d] && first_done[d] < 0) begin
          first_done[d] = cyc;
          chk($sformatf("%s[%0d]", nm, d), out_w[d], want);
        end
      end
      if (first_done[0] >= 0 && first_done[1] >= 0 && first_done[2] >= 0) break;
      @(negedge clk);
      state_in = rnd128();
    end
    for (int d = 0; d < 3; d++) begin
      if (first_done[d] < 0) begin
        n_vec++; n_err++;
        $display("FAIL %s_timeout[%0d]: got no done expected done within 40 cycles", nm, d);
      end
    end
  endtask

  initial begin
    int dcyc;
    int d1, d2;

    build_tables();
    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("model_inv_00",  128'(isb[8'h00]), 128'h52);
    chk("model_inv_16",  128'(isb[8'h16]), 128'hff);

    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy_w), 128'h0);
    chk("reset_done", 128'(done_w), 128'h0);
    chk("reset_out",  out_w[0], 128'h0);
    rst = 1'b0;

    // Identity row and latency per lane count.
    run_job(128'h637C777BF26B6FC53001672BFED7AB76,
            128'h000102030405060708090A0B0C0D0E0F, "identity");
    chk("latency_l1",  128'(first_done[0]), 128'd17);
    chk("latency_l4",  128'(first_done[1]), 128'd5);
    chk("latency_l16", 128'(first_done[2]), 128'd2);

    run_job('0, {16{8'h52}}, "all_zero");
    run_job({16{8'h16}}, {16{8'hff}}, "all_16");

    // Start while busy: second request at cycle 5 must be ignored by LANES=1.
    @(negedge clk);
    start = 1'b1; state_in = {16{8'h16}};
    @(negedge clk);
    start = 1'b0; state_in = rnd128();
    dcyc = -1;
    for (int cyc = 1; cyc <= 40 && dcyc < 0; cyc++) begin
      if (done_w[0]) dcyc = cyc;
      else begin
        @(negedge clk);
        start = (cyc == 4); state_in = (cyc == 4) ? '0 : rnd128();
      end
    end
    start = 1'b0;
    chk("busy_start_done_cycle", 128'(dcyc), 128'd17);
    chk("busy_start_result", out_w[0], {16{8'hff}});
    // Accepted in the idle cycle right after Done.
    run_job(128'h637C777BF26B6FC53001672BFED7AB76,
            128'h000102030405060708090A0B0C0D0E0F, "after_done");

    // Reset in the middle of a LANES=1 job.
    @(negedge clk);
    start = 1'b1; state_in = rnd128();
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_busy", 128'(busy_w), 128'h0);
    chk("midreset_done", 128'(done_w), 128'h0);
    for (int d = 0; d < 3; d++) chk($sformatf("midreset_out[%0d]", d), out_w[d], 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run_job({16{8'h16}}, {16{8'hff}}, "post_reset");

    // Round trip over every byte value.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb;
      xb = 8'(x);
      run_job({16{sb[x]}}, {16{xb}}, "sweep");
    end

    // Back-to-back with Start held high: jobs every N+2 cycles.
    @(negedge clk);
    start = 1'b1;
    d1 = -1; d2 = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      state_in = rnd128();
      @(negedge clk);
      if (done_w[0]) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_period", 128'(d2 - d1), 128'd18);
    repeat (40) @(negedge clk);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      state_in = ($urandom_range(0, 1) == 0) ? rnd128() : {16{sb[$urandom_range(0, 255)]}};
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
